// File: rtl/pio_pkg.sv
// Shared action codes, opcode/operand encodings and pin-mapping helpers for the PIO block.
// Definitions only; no state, no latency.
// No flow control.
package pio_pkg;

    typedef enum logic [5:0] {
        ACT_NONE  = 6'd0,
        ACT_INSTR = 6'd1,
        ACT_PEND  = 6'd2,
        ACT_PULL  = 6'd3,
        ACT_PUSH  = 6'd4,
        ACT_GRPS  = 6'd5,
        ACT_EN    = 6'd6,
        ACT_DIV   = 6'd7,
        ACT_SIDES = 6'd8,
        ACT_IMM   = 6'd9,
        ACT_SHIFT = 6'd10
    } action_e;

    // Opcodes, instruction bits [15:13]
    localparam logic [2:0] OP_JMP  = 3'd0;
    localparam logic [2:0] OP_WAIT = 3'd1;
    localparam logic [2:0] OP_IN   = 3'd2;
    localparam logic [2:0] OP_OUT  = 3'd3;
    localparam logic [2:0] OP_PUSH = 3'd4;
    localparam logic [2:0] OP_MOV  = 3'd5;
    localparam logic [2:0] OP_IRQ  = 3'd6;
    localparam logic [2:0] OP_SET  = 3'd7;

    // JMP conditions, bits [7:5]
    localparam logic [2:0] JC_ALWAYS   = 3'd0;
    localparam logic [2:0] JC_NOT_X    = 3'd1;
    localparam logic [2:0] JC_X_DEC    = 3'd2;
    localparam logic [2:0] JC_NOT_Y    = 3'd3;
    localparam logic [2:0] JC_Y_DEC    = 3'd4;
    localparam logic [2:0] JC_X_NE_Y   = 3'd5;
    localparam logic [2:0] JC_PIN      = 3'd6;
    localparam logic [2:0] JC_NOT_OSRE = 3'd7;

    // Data sources (IN bits [7:5], MOV bits [2:0])
    localparam logic [2:0] SRC_PINS = 3'd0;
    localparam logic [2:0] SRC_X    = 3'd1;
    localparam logic [2:0] SRC_Y    = 3'd2;
    localparam logic [2:0] SRC_NULL = 3'd3;
    localparam logic [2:0] SRC_ISR  = 3'd6;
    localparam logic [2:0] SRC_OSR  = 3'd7;

    // Destinations (OUT/MOV/SET bits [7:5])
    localparam logic [2:0] DST_PINS    = 3'd0;
    localparam logic [2:0] DST_X       = 3'd1;
    localparam logic [2:0] DST_Y       = 3'd2;
    localparam logic [2:0] DST_NULL    = 3'd3;
    localparam logic [2:0] DST_PINDIRS = 3'd4;
    localparam logic [2:0] DST_PC      = 3'd5;

    // MOV operation, bits [4:3]
    localparam logic [1:0] MOV_INV = 2'd1;
    localparam logic [1:0] MOV_REV = 2'd2;

    // Mask of the n lowest bits, n in 0..32
    function automatic logic [31:0] low_mask(input logic [5:0] n);
        logic [31:0] m;
        if (n >= 6'd32) m = '1;
        else            m = (32'd1 << n) - 32'd1;
        return m;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input logic [4:0] s);
        return (v << s) | (v >> (6'd32 - {1'b0, s}));
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] v, input logic [4:0] s);
        return (v >> s) | (v << (6'd32 - {1'b0, s}));
    endfunction

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Shift counters saturate at a full word
    function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 7'd32) ? 6'd32 : s[5:0];
    endfunction

endpackage

// File: rtl/pio_sm.sv
// One PIO state machine: clock divider, decoder/executor, X/Y/ISR/OSR and 4-deep TX/RX FIFOs.
// Executes combinationally from imem[pc] (or the immediate word); all state commits on the same edge.
// Host push drops when TX full; SM stalls on blocking PULL-empty / PUSH-full / unmet WAIT.
module pio_sm
    import pio_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] instr,
    input  logic        imm_vld,
    input  logic        pend_we,
    input  logic        grps_we,
    input  logic        div_we,
    input  logic        shift_we,
    input  logic        tx_push_vld,
    input  logic        rx_pop_vld,
    input  logic [31:0] din,
    input  logic [31:0] gpio_in,
    output logic [4:0]  pc,
    output logic        tx_full,
    output logic        rx_empty,
    output logic [31:0] rx_dat,
    output logic [31:0] pin_mask,
    output logic [31:0] pin_val,
    output logic [31:0] dir_mask,
    output logic [31:0] dir_val
);

    logic [4:0]  pc_q, wrap_top_q, wrap_target_q, delay_q, pull_thresh_q, push_thresh_q;
    logic [31:0] x_q, y_q, isr_q, osr_q, pinctrl_q;
    logic [5:0]  isr_cnt_q, osr_cnt_q;
    logic [15:0] div_int_q;
    logic [7:0]  div_frac_q, frac_acc_q;
    logic [16:0] div_cnt_q;
    logic        in_right_q, out_right_q;

    logic [31:0] tx_mem [4];
    logic [31:0] rx_mem [4];
    logic [1:0]  tx_rd_q, tx_wr_q, rx_rd_q, rx_wr_q;
    logic [2:0]  tx_cnt_q, rx_cnt_q, tx_cnt_n, rx_cnt_n;
    logic        tx_full_q, rx_empty_q, tx_push, rx_pop;

    logic        tick, run, exec_vld, stall, jumped, take, tx_pop, rx_push;
    logic [15:0] cur;
    logic [4:0]  pc_n;
    logic [31:0] x_n, y_n, isr_n, osr_n, in_src, mov_src, mov_val, out_dat;
    logic [5:0]  isr_cnt_n, osr_cnt_n, sh_n, pull_lim;
    logic [8:0]  acc_sum;
    logic [15:0] div_eff;

    logic [4:0]  out_base, set_base, in_base;
    logic [5:0]  out_count;
    logic [2:0]  set_count;
    logic        unused_cfg;

    assign out_base   = pinctrl_q[4:0];
    assign set_base   = pinctrl_q[9:5];
    assign in_base    = pinctrl_q[19:15];
    assign out_count  = pinctrl_q[25:20];
    assign set_count  = pinctrl_q[28:26];
    assign unused_cfg = ^{pinctrl_q[14:10], pinctrl_q[31:29], push_thresh_q};

    assign div_eff  = (div_int_q == 16'd0) ? 16'd1 : div_int_q;
    assign acc_sum  = {1'b0, frac_acc_q} + {1'b0, div_frac_q};
    assign tick     = en && (div_cnt_q <= 17'd1);
    assign run      = tick && (delay_q == 5'd0) && !imm_vld;
    assign exec_vld = imm_vld || run;
    assign cur      = imm_vld ? din[15:0] : instr;
    assign sh_n     = (cur[4:0] == 5'd0) ? 6'd32 : {1'b0, cur[4:0]};
    assign pull_lim = (pull_thresh_q == 5'd0) ? 6'd32 : {1'b0, pull_thresh_q};

    assign pc       = pc_q;
    assign tx_full  = tx_full_q;
    assign rx_empty = rx_empty_q;
    assign rx_dat   = rx_mem[rx_rd_q];

    // Operand selection for IN (bits [7:5]) and MOV (bits [2:0], with invert/reverse)
    always_comb begin
        in_src = '0;
        case (cur[7:5])
            SRC_PINS: in_src = rotr(gpio_in, in_base);
            SRC_X:    in_src = x_q;
            SRC_Y:    in_src = y_q;
            SRC_ISR:  in_src = isr_q;
            SRC_OSR:  in_src = osr_q;
            default:  in_src = '0;
        endcase
        mov_src = '0;
        case (cur[2:0])
            SRC_PINS: mov_src = rotr(gpio_in, in_base);
            SRC_X:    mov_src = x_q;
            SRC_Y:    mov_src = y_q;
            SRC_ISR:  mov_src = isr_q;
            SRC_OSR:  mov_src = osr_q;
            default:  mov_src = '0;
        endcase
        case (cur[4:3])
            MOV_INV: mov_val = ~mov_src;
            MOV_REV: mov_val = bit_rev(mov_src);
            default: mov_val = mov_src;
        endcase
    end

    // Instruction decode/execute; a stall leaves every next-state value at its current value
    always_comb begin
        x_n = x_q; y_n = y_q; isr_n = isr_q; osr_n = osr_q;
        isr_cnt_n = isr_cnt_q; osr_cnt_n = osr_cnt_q;
        pc_n = pc_q; jumped = 1'b0; take = 1'b0; stall = 1'b0;
        tx_pop = 1'b0; rx_push = 1'b0;
        pin_mask = '0; pin_val = '0; dir_mask = '0; dir_val = '0;
        out_dat = out_right_q ? (osr_q & low_mask(sh_n)) : (osr_q >> (6'd32 - sh_n));
        if (exec_vld) begin
            case (cur[15:13])
                OP_JMP: begin
                    case (cur[7:5])
                        JC_ALWAYS:   take = 1'b1;
                        JC_NOT_X:    take = (x_q == 32'd0);
                        JC_X_DEC:    begin take = (x_q != 32'd0); x_n = x_q - 32'd1; end
                        JC_NOT_Y:    take = (y_q == 32'd0);
                        JC_Y_DEC:    begin take = (y_q != 32'd0); y_n = y_q - 32'd1; end
                        JC_X_NE_Y:   take = (x_q != y_q);
                        JC_PIN:      take = gpio_in[in_base];
                        default:     take = (osr_cnt_q < pull_lim);
                    endcase
                    if (take) begin
                        pc_n   = cur[4:0];
                        jumped = 1'b1;
                    end
                end
                OP_WAIT: stall = (gpio_in[cur[4:0]] != cur[7]);
                OP_IN: begin
                    isr_n = in_right_q ? ((isr_q >> sh_n) | (in_src << (6'd32 - sh_n)))
                                       : ((isr_q << sh_n) | (in_src & low_mask(sh_n)));
                    isr_cnt_n = sat_add(isr_cnt_q, sh_n);
                end
                OP_OUT: begin
                    osr_n     = out_right_q ? (osr_q >> sh_n) : (osr_q << sh_n);
                    osr_cnt_n = sat_add(osr_cnt_q, sh_n);
                    case (cur[7:5])
                        DST_PINS: begin
                            pin_mask = rotl(low_mask(out_count), out_base);
                            pin_val  = rotl(out_dat, out_base);
                        end
                        DST_X:       x_n = out_dat;
                        DST_Y:       y_n = out_dat;
                        DST_PINDIRS: begin
                            dir_mask = rotl(low_mask(out_count), out_base);
                            dir_val  = rotl(out_dat, out_base);
                        end
                        DST_PC:      begin pc_n = out_dat[4:0]; jumped = 1'b1; end
                        default:     ;
                    endcase
                end
                OP_PUSH: begin
                    if (cur[7]) begin
                        // PULL: empty+nonblocking loads X so the program can see a default value
                        if (tx_cnt_q != 3'd0) begin
                            osr_n = tx_mem[tx_rd_q]; osr_cnt_n = 6'd0; tx_pop = 1'b1;
                        end else if (cur[5]) begin
                            stall = 1'b1;
                        end else begin
                            osr_n = x_q; osr_cnt_n = 6'd0;
                        end
                    end else begin
                        // PUSH: a nonblocking push into a full RX FIFO loses the word
                        if (rx_cnt_q != 3'd4) begin
                            rx_push = 1'b1; isr_n = '0; isr_cnt_n = 6'd0;
                        end else if (cur[5]) begin
                            stall = 1'b1;
                        end else begin
                            isr_n = '0; isr_cnt_n = 6'd0;
                        end
                    end
                end
                OP_MOV: begin
                    case (cur[7:5])
                        DST_PINS: begin
                            pin_mask = rotl(low_mask(out_count), out_base);
                            pin_val  = rotl(mov_val, out_base);
                        end
                        DST_X:   x_n = mov_val;
                        DST_Y:   y_n = mov_val;
                        default: ;
                    endcase
                end
                OP_SET: begin
                    case (cur[7:5])
                        DST_PINS: begin
                            pin_mask = rotl(low_mask({3'd0, set_count}), set_base);
                            pin_val  = rotl({27'd0, cur[4:0]}, set_base);
                        end
                        DST_X:       x_n = {27'd0, cur[4:0]};
                        DST_Y:       y_n = {27'd0, cur[4:0]};
                        DST_PINDIRS: begin
                            dir_mask = rotl(low_mask({3'd0, set_count}), set_base);
                            dir_val  = rotl({27'd0, cur[4:0]}, set_base);
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Host-written configuration registers; shift directions reset to right-shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_top_q <= 5'd31; wrap_target_q <= 5'd0; pinctrl_q <= '0;
            div_int_q <= 16'd1; div_frac_q <= 8'd0;
            in_right_q <= 1'b1; out_right_q <= 1'b1;
            push_thresh_q <= 5'd0; pull_thresh_q <= 5'd0;
        end else begin
            if (pend_we)  begin wrap_top_q <= din[16:12]; wrap_target_q <= din[11:7]; end
            if (grps_we)  pinctrl_q <= din;
            if (div_we)   begin div_int_q <= din[23:8]; div_frac_q <= din[7:0]; end
            if (shift_we) begin
                in_right_q <= din[18]; out_right_q <= din[19];
                push_thresh_q <= din[24:20]; pull_thresh_q <= din[29:25];
            end
        end
    end

    // Fractional divider: reload int (+1 on fractional carry) at each tick, frozen while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= 17'd1; frac_acc_q <= 8'd0;
        end else if (div_we) begin
            div_cnt_q <= 17'd1; frac_acc_q <= 8'd0;
        end else if (tick) begin
            div_cnt_q  <= {1'b0, div_eff} + {16'd0, acc_sum[8]};
            frac_acc_q <= acc_sum[7:0];
        end else if (en) begin
            div_cnt_q <= div_cnt_q - 17'd1;
        end
    end

    // Program counter, delay counter and working registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0; delay_q <= '0; x_q <= '0; y_q <= '0; isr_q <= '0; osr_q <= '0;
            isr_cnt_q <= '0; osr_cnt_q <= '0;
        end else if (exec_vld && !stall) begin
            x_q <= x_n; y_q <= y_n; isr_q <= isr_n; osr_q <= osr_n;
            isr_cnt_q <= isr_cnt_n; osr_cnt_q <= osr_cnt_n;
            if (imm_vld) begin
                if (jumped) pc_q <= pc_n;
            end else begin
                pc_q    <= jumped ? pc_n : ((pc_q == wrap_top_q) ? wrap_target_q : pc_q + 5'd1);
                delay_q <= cur[12:8];
            end
        end else if (tick && !imm_vld && delay_q != 5'd0) begin
            delay_q <= delay_q - 5'd1;
        end
    end

    assign tx_push  = tx_push_vld && (tx_cnt_q != 3'd4);
    assign rx_pop   = rx_pop_vld && (rx_cnt_q != 3'd0);
    assign tx_cnt_n = tx_cnt_q + {2'd0, tx_push} - {2'd0, tx_pop};
    assign rx_cnt_n = rx_cnt_q + {2'd0, rx_push} - {2'd0, rx_pop};

    // FIFO pointers, occupancy and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_rd_q <= '0; tx_wr_q <= '0; tx_cnt_q <= '0; tx_full_q <= 1'b0;
            rx_rd_q <= '0; rx_wr_q <= '0; rx_cnt_q <= '0; rx_empty_q <= 1'b1;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + 2'd1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 2'd1;
            if (rx_push) rx_wr_q <= rx_wr_q + 2'd1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 2'd1;
            tx_cnt_q   <= tx_cnt_n;
            rx_cnt_q   <= rx_cnt_n;
            tx_full_q  <= (tx_cnt_n == 3'd4);
            rx_empty_q <= (rx_cnt_n == 3'd0);
        end
    end

    // FIFO storage; contents are only read when the occupancy says they are valid
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q] <= din;
        if (rx_push) rx_mem[rx_wr_q] <= isr_q;
    end

endmodule

// File: rtl/pio_unit.sv
// PIO top: shared 32x16 instruction memory, host action decode, four SMs and the GPIO merge.
// Config/FIFO actions take effect at the sampling edge; SM/IMM pin writes land on gpio_out/gpio_dir at that edge.
// Host PUSH to a full TX FIFO is dropped; PULL from an empty RX FIFO leaves dout unchanged.
module pio_unit
    import pio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  action,
    input  logic [4:0]  index,
    input  logic [1:0]  mindex,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic [31:0] gpio_dir,
    output logic [3:0]  tx_full,
    output logic [3:0]  rx_empty
);

    logic [15:0] imem [32];
    logic [3:0]  en_q;
    logic [3:0]  imm_v, pend_v, grps_v, div_v, shift_v, push_v, pull_v;
    logic [4:0]  sm_pc    [4];
    logic [31:0] sm_rx    [4];
    logic [31:0] sm_pmask [4];
    logic [31:0] sm_pval  [4];
    logic [31:0] sm_dmask [4];
    logic [31:0] sm_dval  [4];
    logic [31:0] out_n, dir_n;

    // Decode the host action into per-SM strobes
    always_comb begin
        imm_v = '0; pend_v = '0; grps_v = '0; div_v = '0;
        shift_v = '0; push_v = '0; pull_v = '0;
        case (action)
            ACT_PEND:  pend_v[mindex]  = 1'b1;
            ACT_PULL:  pull_v[mindex]  = 1'b1;
            ACT_PUSH:  push_v[mindex]  = 1'b1;
            ACT_GRPS:  grps_v[mindex]  = 1'b1;
            ACT_DIV:   div_v[mindex]   = 1'b1;
            ACT_IMM:   imm_v[mindex]   = 1'b1;
            ACT_SHIFT: shift_v[mindex] = 1'b1;
            default:   ;
        endcase
    end

    // Instruction memory, enable mask and the host read-back register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) imem[i] <= '0;
            en_q <= '0;
            dout <= '0;
        end else begin
            if (action == ACT_INSTR) imem[index] <= din[15:0];
            if (action == ACT_EN)    en_q <= din[3:0];
            if (action == ACT_PULL && !rx_empty[mindex]) dout <= sm_rx[mindex];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_sm
        pio_sm u_sm (
            .clk         (clk),
            .rst_n       (reset),
            .en          (en_q[g]),
            .instr       (imem[sm_pc[g]]),
            .imm_vld     (imm_v[g]),
            .pend_we     (pend_v[g]),
            .grps_we     (grps_v[g]),
            .div_we      (div_v[g]),
            .shift_we    (shift_v[g]),
            .tx_push_vld (push_v[g]),
            .rx_pop_vld  (pull_v[g]),
            .din         (din),
            .gpio_in     (gpio_in),
            .pc          (sm_pc[g]),
            .tx_full     (tx_full[g]),
            .rx_empty    (rx_empty[g]),
            .rx_dat      (sm_rx[g]),
            .pin_mask    (sm_pmask[g]),
            .pin_val     (sm_pval[g]),
            .dir_mask    (sm_dmask[g]),
            .dir_val     (sm_dval[g])
        );
    end

    // Merge SM pin writes in ascending order so the highest-numbered SM wins a collision
    always_comb begin
        out_n = gpio_out;
        dir_n = gpio_dir;
        for (int i = 0; i < 4; i++) begin
            out_n = (out_n & ~sm_pmask[i]) | (sm_pval[i] & sm_pmask[i]);
            dir_n = (dir_n & ~sm_dmask[i]) | (sm_dval[i] & sm_dmask[i]);
        end
    end

    // Pad output and direction registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_out <= '0;
            gpio_dir <= '0;
        end else begin
            gpio_out <= out_n;
            gpio_dir <= dir_n;
        end
    end

endmodule

// File: tb/tb_pio_unit.sv
module tb_pio_unit;

    localparam logic [5:0] A_INSTR = 6'd1, A_PEND = 6'd2, A_PULL = 6'd3, A_PUSH = 6'd4,
                           A_GRPS = 6'd5, A_EN = 6'd6, A_DIV = 6'd7, A_IMM = 6'd9;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  action = 6'd0;
    logic [4:0]  index = 5'd0;
    logic [1:0]  mindex = 2'd0;
    logic [31:0] din = 32'd0;
    logic [31:0] gpio_in = 32'd0;
    logic [31:0] dout, gpio_out, gpio_dir;
    logic [3:0]  tx_full, rx_empty;

    int total = 0;
    int bad = 0;

    pio_unit dut (
        .clk      (clk),
        .reset    (reset),
        .action   (action),
        .index    (index),
        .mindex   (mindex),
        .din      (din),
        .dout     (dout),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_dir (gpio_dir),
        .tx_full  (tx_full),
        .rx_empty (rx_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one action for exactly one sampling edge, then return just after that edge
    task automatic host(input logic [5:0] act, input logic [1:0] mi, input logic [4:0] idx,
                        input logic [31:0] d);
        action = act; mindex = mi; index = idx; din = d;
        @(posedge clk); #1;
        action = 6'd0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int toggles;
        logic prev;
        logic [31:0] exp_seq [8];

        // Reset state
        do_reset();
        check("rst_gpio_out", gpio_out, 32'h0);
        check("rst_gpio_dir", gpio_dir, 32'h0);
        check("rst_dout", dout, 32'h0);
        check("rst_tx_full", {28'd0, tx_full}, 32'h0);
        check("rst_rx_empty", {28'd0, rx_empty}, 32'hF);

        // Immediate SET on a disabled SM, set_count = 1
        host(A_GRPS, 2'd0, 5'd0, 32'h0400_0000);
        host(A_IMM, 2'd0, 5'd0, 32'h0000_E001);
        check("imm_set_pins", gpio_out, 32'h0000_0001);
        host(A_IMM, 2'd0, 5'd0, 32'h0000_E081);
        check("imm_set_pindirs", gpio_dir, 32'h0000_0001);

        // Toggle program with divider 2.5: 100 clocks hold exactly 40 instructions
        do_reset();
        host(A_INSTR, 2'd0, 5'd0, 32'hE001);
        host(A_INSTR, 2'd0, 5'd1, 32'hE000);
        host(A_PEND, 2'd0, 5'd0, 32'h0000_1000);
        host(A_GRPS, 2'd0, 5'd0, 32'h0400_0000);
        host(A_DIV, 2'd0, 5'd0, 32'h0000_0280);
        host(A_EN, 2'd0, 5'd0, 32'h1);
        wait_clks(20);
        toggles = 0;
        prev = gpio_out[0];
        for (int i = 0; i < 100; i++) begin
            wait_clks(1);
            if (gpio_out[0] != prev) toggles++;
            prev = gpio_out[0];
        end
        check("div_toggles_100clk", toggles, 32'd40);

        // SM2: blocking PULL then MOV pins, OSR with out_count 32
        do_reset();
        host(A_INSTR, 2'd0, 5'd0, 32'h80A0);
        host(A_INSTR, 2'd0, 5'd1, 32'hA007);
        host(A_GRPS, 2'd2, 5'd0, 32'h0200_0000);
        host(A_EN, 2'd0, 5'd0, 32'h4);
        host(A_PUSH, 2'd2, 5'd0, 32'hDEAD_BEEF);
        wait_clks(10);
        check("sm2_mov_pins", gpio_out, 32'hDEAD_BEEF);
        check("sm2_tx_full", {28'd0, tx_full}, 32'h0);

        // TX FIFO fill on disabled SM1; fifth word must be dropped
        do_reset();
        host(A_GRPS, 2'd1, 5'd0, 32'h0200_0000);
        for (int k = 1; k <= 5; k++) begin
            host(A_PUSH, 2'd1, 5'd0, k);
            check($sformatf("tx_full_after_push%0d", k), {28'd0, tx_full}, (k >= 4) ? 32'h2 : 32'h0);
        end
        for (int k = 1; k <= 4; k++) begin
            host(A_IMM, 2'd1, 5'd0, 32'h80A0);
            if (k == 1) check("tx_full_after_pop", {28'd0, tx_full}, 32'h0);
            host(A_IMM, 2'd1, 5'd0, 32'hA007);
            check($sformatf("tx_word%0d", k), gpio_out, k);
        end
        host(A_IMM, 2'd1, 5'd0, 32'h8080);
        host(A_IMM, 2'd1, 5'd0, 32'hA007);
        check("fifth_dropped_osr_gets_x", gpio_out, 32'h0);

        // SET X 3; JMP X-- self; IN X,32; PUSH; park -> one word of 0xFFFFFFFF
        do_reset();
        host(A_INSTR, 2'd0, 5'd0, 32'hE023);
        host(A_INSTR, 2'd0, 5'd1, 32'h0041);
        host(A_INSTR, 2'd0, 5'd2, 32'h4020);
        host(A_INSTR, 2'd0, 5'd3, 32'h8020);
        host(A_INSTR, 2'd0, 5'd4, 32'h0004);
        host(A_EN, 2'd0, 5'd0, 32'h1);
        wait_clks(20);
        check("rx_empty_after_push", {28'd0, rx_empty}, 32'hE);
        host(A_PULL, 2'd0, 5'd0, 32'h0);
        check("pull_dout", dout, 32'hFFFF_FFFF);
        check("rx_empty_after_pull", {28'd0, rx_empty}, 32'hF);

        // Wrap: target 2, top 4; each instruction writes its own address onto pins [2:0]
        do_reset();
        for (int k = 0; k < 5; k++) host(A_INSTR, 2'd0, k[4:0], 32'hE000 | k);
        host(A_GRPS, 2'd0, 5'd0, 32'h0C00_0000);
        host(A_PEND, 2'd0, 5'd0, 32'h0000_4100);
        exp_seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd2, 32'd3, 32'd4};
        host(A_EN, 2'd0, 5'd0, 32'h1);
        for (int i = 0; i < 8; i++) begin
            wait_clks(1);
            check($sformatf("wrap_step%0d", i), gpio_out, exp_seq[i]);
        end

        // Reset mid-run clears outputs without waiting for a clock
        reset = 1'b0;
        #1;
        check("midrun_reset_gpio", gpio_out, 32'h0);
        wait_clks(2);
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
